instr_fetch_decode: RTL

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/uirsa_pkg.sv | 52 +++++
 rtl/instr_field_decode.sv | 48 ++++
 rtl/instr_fetch_decode.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uirsa_pkg.sv
// Shared definitions for the fetch/decode slice.
// Contents: primary opcode constants, extended-opcode constants, the
// fetch FSM state enum, and a legality helper for primary opcodes.
package uirsa_pkg;

    // Primary opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_ADDIS = 6'd15;
    localparam logic [5:0] OP_B     = 6'd18;
    localparam logic [5:0] OP_XL    = 6'd19;
    localparam logic [5:0] OP_RLWNM = 6'd23;
    localparam logic [5:0] OP_ORI   = 6'd24;
    localparam logic [5:0] OP_XORI  = 6'd26;
    localparam logic [5:0] OP_ANDI  = 6'd28;
    localparam logic [5:0] OP_X     = 6'd31;
    localparam logic [5:0] OP_LWZ   = 6'd32;
    localparam logic [5:0] OP_LBZ   = 6'd34;
    localparam logic [5:0] OP_STW   = 6'd36;
    localparam logic [5:0] OP_STWU  = 6'd37;
    localparam logic [5:0] OP_STB   = 6'd38;
    localparam logic [5:0] OP_LHZ   = 6'd40;
    localparam logic [5:0] OP_LHA   = 6'd42;
    localparam logic [5:0] OP_STH   = 6'd44;
    localparam logic [5:0] OP_LD    = 6'd58;
    localparam logic [5:0] OP_STD   = 6'd62;

    // XO-form extended opcodes (bits [9:1]) under OP_X
    localparam logic [8:0] XO_ADD = 9'd266;
    localparam logic [8:0] XO_SUB = 9'd40;

    // X-form extended opcodes (bits [10:1]) under OP_X
    localparam logic [9:0] XOX_AND = 10'd28;
    localparam logic [9:0] XOX_XOR = 10'd316;
    localparam logic [9:0] XOX_OR  = 10'd444;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fsm_state_t;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ADDIS, OP_B, OP_XL, OP_RLWNM, OP_ORI, OP_XORI,
            OP_ANDI, OP_X, OP_LWZ, OP_LBZ, OP_STW, OP_STWU, OP_STB,
            OP_LHZ, OP_LHA, OP_STH, OP_LD, OP_STD: is_legal_opcode = 1'b1;
            default:                               is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction for one 32-bit instruction word.
// Ports:
//   ir      - instruction register contents
//   opcode .. li - decoded fields, straight bit slices of ir except xoxo
//   xoxo    - XO-form opcode, nonzero only for OP_X with ADD or SUB
//   legal   - primary opcode is in the supported set
module instr_field_decode
    import uirsa_pkg::*;
(
    input  logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [8:0]  xoxo,
    output logic [9:0]  xox,
    output logic        rc,
    output logic        aa,
    output logic [13:0] ds,
    output logic [15:0] si,
    output logic [1:0]  xods,
    output logic [4:0]  rt_idx,
    output logic [4:0]  ra_idx,
    output logic [4:0]  rb_idx,
    output logic [23:0] li,
    output logic        legal
);

    assign opcode = ir[31:26];
    assign rt_idx = ir[25:21];
    assign ra_idx = ir[20:16];
    assign rb_idx = ir[15:11];
    assign xox    = ir[10:1];
    assign rc     = ir[0];
    assign aa     = ir[1];
    assign si     = ir[15:0];
    assign ds     = ir[15:2];
    assign xods   = ir[1:0];
    assign li     = ir[25:2];
    assign legal  = is_legal_opcode(ir[31:26]);

    // xoxo is forced to zero for every X-form word (e.g. OR with XO 444),
    // so downstream ADD/SUB detection cannot alias an X-form encoding.
    always_comb begin
        xoxo = '0;
        if (ir[31:26] == OP_X && (ir[9:1] == XO_ADD || ir[9:1] == XO_SUB)) begin
            xoxo = ir[9:1];
        end
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch FSM with PC, instruction register and decode.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   imem_req, imem_addr   - one-cycle fetch request and word address (PC)
//   imem_ack, imem_rdata  - fetch completion and instruction word
//   redirect_valid/_pc    - taken-branch redirect from execute
//   dec_valid, dec_ready  - decoded instruction handshake
//   opcode .. li, pc_out  - decoded fields and PC of the issued word
//   halted                - set by an illegal opcode, cleared only by reset
//   fsm_state             - current FSM state for observation
//
// Handshake: dec_valid rises one cycle after the accepted ack and then holds,
// with all fields and pc_out stable, until a cycle with dec_ready=1 (transfer)
// or redirect_valid=1 (squash, no transfer). dec_valid never depends
// combinationally on dec_ready.
module instr_fetch_decode
    import uirsa_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [5:0]  opcode,
    output logic [8:0]  xoxo,
    output logic [9:0]  xox,
    output logic        rc,
    output logic        aa,
    output logic [13:0] ds,
    output logic [15:0] si,
    output logic [1:0]  xods,
    output logic [4:0]  rt_idx,
    output logic [4:0]  ra_idx,
    output logic [4:0]  rb_idx,
    output logic [23:0] li,
    output logic [63:0] pc_out,
    output logic        halted,
    output fsm_state_t  fsm_state
);

    fsm_state_t  state_q;
    logic [63:0] pc_q;
    logic [31:0] ir_q;
    logic        drop_q;
    logic        legal;

    instr_field_decode u_decode (
        .ir     (ir_q),
        .opcode (opcode),
        .xoxo   (xoxo),
        .xox    (xox),
        .rc     (rc),
        .aa     (aa),
        .ds     (ds),
        .si     (si),
        .xods   (xods),
        .rt_idx (rt_idx),
        .ra_idx (ra_idx),
        .rb_idx (rb_idx),
        .li     (li),
        .legal  (legal)
    );

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign fsm_state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            drop_q    <= 1'b0;
            imem_req  <= 1'b0;
            dec_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            case (state_q)
                // The request is registered, so it is visible during the
                // first WAIT cycle. While drop_q is set a squashed fetch is
                // still in flight; no new request goes out until its ack
                // has been swallowed, keeping one request outstanding.
                ST_FETCH: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                        if (imem_ack) drop_q <= 1'b0;
                    end else if (drop_q) begin
                        if (imem_ack) drop_q <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        state_q <= ST_FETCH;
                        // An ack in this same cycle retires the old request.
                        drop_q  <= !imem_ack;
                    end else if (imem_ack) begin
                        ir_q      <= imem_rdata;
                        // Illegal words never present dec_valid.
                        dec_valid <= is_legal_opcode(imem_rdata[31:26]);
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (redirect_valid) begin
                        pc_q      <= redirect_pc;
                        dec_valid <= 1'b0;
                        state_q   <= ST_FETCH;
                    end else if (!legal) begin
                        dec_valid <= 1'b0;
                        halted    <= 1'b1;
                        state_q   <= ST_HALT;
                    end else if (dec_ready) begin
                        pc_q      <= pc_q + 64'd4;
                        dec_valid <= 1'b0;
                        state_q   <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    dec_valid <= 1'b0;
                    halted    <= 1'b1;
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
